// File: rtl/lane_frame_painter.sv
// lane_frame_painter: command-driven raster engine (clear/floors/obstacle/sprite), one pixel per clock; PAINTER_TRANSPARENT_EN makes sprite 0-bits transparent
module lane_frame_painter #(
  parameter int SCR_W = 160,
  parameter int SCR_H = 120,
  parameter int LANES = 3,
  parameter int LANE_PITCH = 40,
  parameter int FLOOR_H = 5,
  parameter int TOP_GAP = 15,
  parameter int BOT_GAP = 5,
  parameter int OBS_W = 2,
  parameter int SPR_W = 8,
  parameter int SPR_H = 8,
  parameter int COL_W = 3,
  parameter logic [COL_W-1:0] C_BG = 3'b000,
  parameter logic [COL_W-1:0] C_FLOOR = 3'b101,
  parameter logic [COL_W-1:0] C_OBS = 3'b110,
  parameter logic [COL_W-1:0] C_SPR = 3'b111,
  localparam int XW = $clog2(SCR_W),
  localparam int YW = $clog2(SCR_H)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [XW-1:0]            cmd_x,
  input  logic [YW-1:0]            cmd_y,
  input  logic [2*LANES-1:0]       cmd_shape,
  input  logic [SPR_W*SPR_H-1:0]   cmd_bitmap,
  output logic [XW-1:0]            x,
  output logic [YW-1:0]            y,
  output logic [COL_W-1:0]         color,
  output logic                     plot,
  output logic                     busy,
  output logic                     done
);
  typedef enum logic [2:0] {IDLE, CLR, FLR, OBS, SPR, DONE} state_t;
  typedef logic [XW:0] xe_t;
  typedef logic [YW:0] ye_t;
  state_t state, nxt;
  xe_t cx, px;
  ye_t cy, py;
  logic [XW-1:0] l_x;
  logic [YW-1:0] l_y;
  logic [2*LANES-1:0] l_shape, shs;
  logic [SPR_W*SPR_H-1:0] l_bmp, bmp_sh;
  logic [COL_W-1:0] obs_c, pcol;
  logic pix, last_col, last, flr, on_scr, spr_vis;
  int wl, hl, k, o;
  function automatic logic is_floor(input int yy);
    return yy < LANES*LANE_PITCH && yy % LANE_PITCH >= LANE_PITCH-FLOOR_H;
  endfunction
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk)
    if (reset) begin
      cx <= '0;
      cy <= '0;
    end else if (state == IDLE) begin
      cx <= '0;
      cy <= '0;
      if (cmd_valid) begin
        l_x <= cmd_x;
        l_y <= cmd_y;
        l_shape <= cmd_shape;
        l_bmp <= cmd_bitmap;
      end
    end else if (pix) begin
      cx <= last_col ? '0 : cx + 1'b1;
      cy <= last_col ? cy + 1'b1 : cy;
    end
  always_comb begin
    pix = state inside {CLR, FLR, OBS, SPR};
    wl = state == OBS ? OBS_W : state == SPR ? SPR_W : SCR_W;
    hl = state == FLR ? LANES*FLOOR_H : state == SPR ? SPR_H : SCR_H;
    last_col = int'(cx) == wl-1;
    last = last_col && int'(cy) == hl-1;
    px = state inside {OBS, SPR} ? xe_t'(int'(l_x) + int'(cx)) : cx;
    py = state == FLR ? ye_t'(int'(cy)/FLOOR_H*LANE_PITCH + LANE_PITCH-FLOOR_H + int'(cy)%FLOOR_H)
       : state == SPR ? ye_t'(int'(l_y) + int'(cy)) : cy;
    k = int'(py) / LANE_PITCH;
    o = int'(py) % LANE_PITCH;
    shs = l_shape >> (2*k);
    flr = is_floor(int'(py));
    bmp_sh = l_bmp >> (int'(cy)*SPR_W + int'(cx));
    on_scr = int'(px) < SCR_W && int'(py) < SCR_H;
    obs_c = flr ? C_FLOOR : k >= LANES ? C_BG
          : shs[1:0] == 2'b11 ? C_OBS
          : shs[1:0] == 2'b01 ? (o < TOP_GAP ? C_BG : C_OBS)
          : shs[1:0] == 2'b10 ? ((o >= LANE_PITCH-FLOOR_H-BOT_GAP && o < LANE_PITCH-FLOOR_H) ? C_BG : C_OBS)
          : C_BG;
    pcol = state == FLR ? C_FLOOR : state == OBS ? obs_c
         : state == SPR && bmp_sh[0] ? C_SPR : flr ? C_FLOOR : C_BG;
`ifdef PAINTER_TRANSPARENT_EN
    spr_vis = bmp_sh[0];
`else
    spr_vis = 1'b1;
`endif
    plot = pix && on_scr && (state != SPR || spr_vis);
    x = pix ? px[XW-1:0] : '0;
    y = pix ? py[YW-1:0] : '0;
    color = pix ? pcol : '0;
    busy = pix;
    done = state == DONE;
    cmd_ready = state == IDLE;
    nxt = state == IDLE ? (!cmd_valid ? IDLE : cmd_op == 2'd0 ? CLR : cmd_op == 2'd1 ? FLR : cmd_op == 2'd2 ? OBS : SPR)
        : state == DONE ? IDLE : pix && last ? DONE : state;
  end
endmodule

// File: tb/tb_lane_frame_painter.sv
// tb_lane_frame_painter: randomized and directed checks of lane_frame_painter against a rule-level pixel model
module tb_lane_frame_painter;
  localparam int SW = 160, SH = 120, LN = 3, LP = 40, FH = 5, TG = 15, BG = 5, OW = 2;
  localparam int XW = $clog2(SW), YW = $clog2(SH);
  typedef struct {int x; int y; logic [2:0] c; logic p;} px_t;
  logic clk = 0, reset = 1, cmd_valid = 0, cmd_ready, plot, busy, done;
  logic [1:0] cmd_op = 0;
  logic [XW-1:0] cmd_x = 0, x;
  logic [YW-1:0] cmd_y = 0, y;
  logic [2*LN-1:0] cmd_shape = 0;
  logic [63:0] cmd_bitmap = 0;
  logic [2:0] color;
  int checks = 0, errors = 0, nplot = 0, eplot = 0;
  px_t exp_q[$];
  logic [2:0] obs_c [0:SW-1][0:SH-1];
  logic obs_p [0:SW-1][0:SH-1];

  lane_frame_painter dut (.clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_shape(cmd_shape), .cmd_bitmap(cmd_bitmap),
    .x(x), .y(y), .color(color), .plot(plot), .busy(busy), .done(done));

  always #5 clk = ~clk;

  function automatic logic [2:0] bgm(input int yy);
    return (yy < LN*LP && yy % LP >= LP-FH) ? 3'b101 : 3'b000;
  endfunction

  function automatic logic [2:0] obsm(input int yy, input logic [5:0] sh);
    int ln, off;
    logic [1:0] s;
    if (bgm(yy) == 3'b101) return 3'b101;
    if (yy >= LN*LP) return 3'b000;
    ln = yy / LP;
    off = yy % LP;
    s = 2'(sh >> (2*ln));
    case (s)
      2'b00: return 3'b000;
      2'b01: return off < TG ? 3'b000 : 3'b110;
      2'b10: return (off >= LP-FH-BG && off < LP-FH) ? 3'b000 : 3'b110;
      default: return 3'b110;
    endcase
  endfunction

  task automatic build(input logic [1:0] op, input int ax, input int ay, input logic [5:0] sh, input logic [63:0] bm);
    exp_q.delete();
    case (op)
      2'd0: for (int yy = 0; yy < SH; yy++) for (int xx = 0; xx < SW; xx++) exp_q.push_back('{xx, yy, bgm(yy), 1'b1});
      2'd1: for (int ln = 0; ln < LN; ln++) for (int off = LP-FH; off < LP; off++)
              for (int xx = 0; xx < SW; xx++) exp_q.push_back('{xx, ln*LP+off, 3'b101, 1'b1});
      2'd2: for (int yy = 0; yy < SH; yy++) for (int c = 0; c < OW; c++)
              exp_q.push_back('{ax+c, yy, obsm(yy, sh), ax+c < SW});
      default: for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) begin
        logic b, vis;
        b = 1'(bm >> (r*8+c));
`ifdef PAINTER_TRANSPARENT_EN
        vis = b;
`else
        vis = 1'b1;
`endif
        exp_q.push_back('{ax+c, ay+r, b ? 3'b111 : bgm(ay+r), ax+c < SW && ay+r < SH && vis});
      end
    endcase
  endtask

  task automatic accept(input logic [1:0] op, input int ax, input int ay, input logic [5:0] sh, input logic [63:0] bm, input string nm);
    int n = 0;
    cmd_op = op; cmd_x = XW'(ax); cmd_y = YW'(ay); cmd_shape = sh; cmd_bitmap = bm; cmd_valid = 1;
    while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s accept: cmd_ready=%b want 1", nm, cmd_ready); end
    @(negedge clk);
    cmd_valid = 0; cmd_op = 2'($urandom); cmd_x = XW'($urandom); cmd_y = YW'($urandom);
    cmd_shape = 6'($urandom); cmd_bitmap = {$urandom, $urandom};
  endtask

  task automatic run_cmd(input logic [1:0] op, input int ax, input int ay, input logic [5:0] sh, input logic [63:0] bm, input string nm);
    int nbad = 0;
    string first = "";
    build(op, ax, ay, sh, bm);
    for (int i = 0; i < SW; i++) for (int j = 0; j < SH; j++) begin obs_c[i][j] = 0; obs_p[i][j] = 0; end
    accept(op, ax, ay, sh, bm, nm);
    nplot = 0; eplot = 0;
    foreach (exp_q[i]) begin
      eplot += int'(exp_q[i].p);
      if (plot === 1'b1) begin
        nplot++;
        if (x < SW && y < SH) begin obs_c[x][y] = color; obs_p[x][y] = 1; end
      end
      if (busy !== 1'b1 || plot !== exp_q[i].p || x !== XW'(exp_q[i].x) || y !== YW'(exp_q[i].y) ||
          (exp_q[i].p && color !== exp_q[i].c)) begin
        if (nbad == 0) first = $sformatf("pix %0d got x=%0d y=%0d c=%0d p=%b busy=%b want x=%0d y=%0d c=%0d p=%b",
          i, x, y, color, plot, busy, XW'(exp_q[i].x), YW'(exp_q[i].y), exp_q[i].c, exp_q[i].p);
        nbad++;
      end
      @(negedge clk);
    end
    checks++;
    if (nbad !== 0) begin errors++; $display("FAIL %s pixels: %0d bad, first %s", nm, nbad, first); end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || plot !== 1'b0) begin
      errors++; $display("FAIL %s done: done=%b busy=%b plot=%b want 1 0 0", nm, done, busy, plot);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle: done=%b ready=%b want 0 1", nm, done, cmd_ready);
    end
    checks++;
    if (nplot !== eplot) begin errors++; $display("FAIL %s plots: got %0d want %0d", nm, nplot, eplot); end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, plot, busy, done} !== 4'b1000 || x !== 0 || y !== 0 || color !== 0) begin
      errors++; $display("FAIL reset: ready=%b plot=%b busy=%b done=%b x=%0d y=%0d c=%0d want 1 0 0 0 0 0 0",
        cmd_ready, plot, busy, done, x, y, color);
    end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_clear;
    run_cmd(2'd0, 0, 0, 0, 0, "clear");
    checks++;
    if (nplot !== 19200) begin errors++; $display("FAIL clear count: got %0d want 19200", nplot); end
    checks++;
    if (obs_c[0][0] !== 3'b000 || obs_c[5][37] !== 3'b101 || obs_c[159][119] !== 3'b101) begin
      errors++; $display("FAIL clear spots: got %0d %0d %0d want 0 5 5", obs_c[0][0], obs_c[5][37], obs_c[159][119]);
    end
  endtask

  task automatic test_obst;
    run_cmd(2'd2, 156, 0, 6'b11_10_01, 0, "obst");
    checks++;
    if (nplot !== 240) begin errors++; $display("FAIL obst count: got %0d want 240", nplot); end
    checks++;
    if (obs_c[156][10] !== 3'b000 || obs_c[156][20] !== 3'b110 || obs_c[156][72] !== 3'b000 ||
        obs_c[156][60] !== 3'b110 || obs_c[156][100] !== 3'b110 || obs_c[156][117] !== 3'b101) begin
      errors++; $display("FAIL obst spots: got %0d %0d %0d %0d %0d %0d want 0 6 0 6 6 5", obs_c[156][10],
        obs_c[156][20], obs_c[156][72], obs_c[156][60], obs_c[156][100], obs_c[156][117]);
    end
  endtask

  task automatic test_sprite;
    run_cmd(2'd3, 25, 108, 0, 64'h1, "sprite");
    checks++;
    if (obs_p[25][108] !== 1'b1 || obs_c[25][108] !== 3'b111) begin
      errors++; $display("FAIL sprite set: p=%b c=%0d want 1 7", obs_p[25][108], obs_c[25][108]);
    end
    checks++;
`ifdef PAINTER_TRANSPARENT_EN
    if (obs_p[26][108] !== 1'b0) begin errors++; $display("FAIL sprite clear: p=%b want 0", obs_p[26][108]); end
`else
    if (obs_p[26][108] !== 1'b1 || obs_c[26][108] !== 3'b000) begin
      errors++; $display("FAIL sprite clear: p=%b c=%0d want 1 0", obs_p[26][108], obs_c[26][108]);
    end
`endif
  endtask

  task automatic test_clip;
    run_cmd(2'd3, 156, 116, 0, '1, "clip");
    checks++;
    if (nplot !== 16) begin errors++; $display("FAIL clip count: got %0d want 16", nplot); end
    run_cmd(2'd3, 156, 116, 0, {$urandom, $urandom}, "clip_rand");
  endtask

  task automatic test_reset_mid;
    accept(2'd0, 0, 0, 0, 0, "mid");
    repeat (500) @(negedge clk);
    reset = 1;
    @(negedge clk);
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL mid reset: plot=%b busy=%b ready=%b want 0 0 1", plot, busy, cmd_ready);
    end
    reset = 0;
    @(negedge clk);
    run_cmd(2'd1, 0, 0, 0, 0, "floors_after_reset");
    checks++;
    if (nplot !== 2400) begin errors++; $display("FAIL floors count: got %0d want 2400", nplot); end
  endtask

  task automatic test_back_to_back;
    int acc_q[$], done_q[$];
    int bad = 0;
    cmd_op = 2'd1; cmd_valid = 1;
    for (int t = 0; t <= 4803; t++) begin
      if (cmd_ready && busy) bad++;
      if (cmd_ready && cmd_valid) acc_q.push_back(t);
      if (done) done_q.push_back(t);
      @(negedge clk);
    end
    cmd_valid = 0;
    @(negedge clk);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL b2b ready_while_busy: got %0d want 0", bad); end
    checks++;
    if (acc_q.size() !== 2 || acc_q[0] !== 0 || acc_q[1] !== 2402) begin
      errors++; $display("FAIL b2b accepts: got %p want 0,2402", acc_q);
    end
    checks++;
    if (done_q.size() !== 2 || done_q[0] !== 2401 || done_q[1] !== 4803) begin
      errors++; $display("FAIL b2b done: got %p want 2401,4803", done_q);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++)
      run_cmd(2'($urandom_range(1, 3)), int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
              6'($urandom), {$urandom, $urandom}, $sformatf("rand%0d", i));
  endtask

  initial begin
    test_reset();
    test_clear();
    test_obst();
    test_sprite();
    test_clip();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
